// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker: polynomial selection,
// LFSR geometry and checker state encoding.
package prbs_pkg;

   localparam int LFSR_W = 31;

   localparam logic [1:0] MODE_PRBS7  = 2'b00;
   localparam logic [1:0] MODE_PRBS15 = 2'b01;
   localparam logic [1:0] MODE_PRBS23 = 2'b10;
   localparam logic [1:0] MODE_PRBS31 = 2'b11;

   localparam int LEN_PRBS7  = 7;
   localparam int LEN_PRBS15 = 15;
   localparam int LEN_PRBS23 = 23;
   localparam int LEN_PRBS31 = 31;

   localparam int TAP_PRBS7  = 6;
   localparam int TAP_PRBS15 = 14;
   localparam int TAP_PRBS23 = 18;
   localparam int TAP_PRBS31 = 28;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'b00,
      ST_VERIFY = 2'b01,
      ST_LOCKED = 2'b10
   } chk_state_e;

   function automatic int prbs_len(input logic [1:0] mode);
      case (mode)
         MODE_PRBS7:  return LEN_PRBS7;
         MODE_PRBS15: return LEN_PRBS15;
         MODE_PRBS23: return LEN_PRBS23;
         default:     return LEN_PRBS31;
      endcase
   endfunction

   function automatic int prbs_tap(input logic [1:0] mode);
      case (mode)
         MODE_PRBS7:  return TAP_PRBS7;
         MODE_PRBS15: return TAP_PRBS15;
         MODE_PRBS23: return TAP_PRBS23;
         default:     return TAP_PRBS31;
      endcase
   endfunction

   function automatic logic [LFSR_W-1:0] prbs_mask(input logic [1:0] mode);
      return LFSR_W'((64'd1 << prbs_len(mode)) - 64'd1);
   endfunction

   // Number of received words needed to fully seed an N-bit checker LFSR.
   function automatic int fill_words(input logic [1:0] mode, input int data_w);
      return (prbs_len(mode) + data_w - 1) / data_w;
   endfunction

endpackage

// File: rtl/prbs_step.sv
// Combinational DATA_W-step advance of the 31-bit LFSR for the selected polynomial.
// USE_FB=1 emits the feedback bits instead of the shifted-out bits.
module prbs_step
   import prbs_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter bit USE_FB = 1'b0
) (
   input  logic [LFSR_W-1:0] i_state,
   input  logic [1:0]        i_mode,
   output logic [DATA_W-1:0] o_word,
   output logic [LFSR_W-1:0] o_next_state
);

   logic [LFSR_W-1:0] w_mask;
   logic [LFSR_W-1:0] w_s;
   logic [4:0]        w_msb;
   logic [4:0]        w_tap;
   logic              w_out;
   logic              w_fb;

   always_comb begin
      w_mask = prbs_mask(i_mode);
      w_msb  = 5'(prbs_len(i_mode) - 1);
      w_tap  = 5'(prbs_tap(i_mode) - 1);
      w_s    = i_state & w_mask;
      w_out  = 1'b0;
      w_fb   = 1'b0;
      o_word = '0;
      for (int i = 0; i < DATA_W; i++) begin
         w_out = w_s[w_msb];
         w_fb  = w_s[w_msb] ^ w_s[w_tap];
         o_word[DATA_W-1-i] = USE_FB ? w_fb : w_out;
         w_s   = ((w_s << 1) | LFSR_W'(w_fb)) & w_mask;
      end
      o_next_state = w_s;
   end

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS7/15/23/31 word generator with error injection, plus a self-seeding
// checker that locks onto a received stream and counts bit errors.
module prbs_gen_chk
   import prbs_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 4,
   parameter int ERR_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic              inject_err,
   output logic [DATA_W-1:0] gen_data,
   output logic              gen_valid,
   input  logic [DATA_W-1:0] chk_data,
   input  logic              chk_valid,
   input  logic              clr_cnt,
   output logic              locked,
   output logic [ERR_W-1:0]  err_count,
   output logic              err_word
);

   localparam int FILL_W = $clog2(LFSR_W + 1);
   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);
   localparam int POP_W  = $clog2(DATA_W + 1);
   localparam int SUM_W  = ((ERR_W > POP_W) ? ERR_W : POP_W) + 1;

   logic [1:0]        r_mode;
   logic [LFSR_W-1:0] r_gen_lfsr;
   logic [DATA_W-1:0] r_gen_data;
   logic              r_gen_valid;

   chk_state_e        r_state, w_state_next;
   logic [LFSR_W-1:0] r_chk_lfsr, w_chk_lfsr_next;
   logic [FILL_W-1:0] r_fill_cnt, w_fill_next;
   logic [GOOD_W-1:0] r_good_cnt, w_good_next;
   logic [BAD_W-1:0]  r_bad_cnt, w_bad_next;
   logic [ERR_W-1:0]  r_err_count;
   logic              r_err_word, w_err_word_next;
   logic              w_err_acc;

   logic              w_mode_chg;
   logic [LFSR_W-1:0] w_mask;
   logic [LFSR_W-1:0] w_gen_next, w_chk_next, w_seed;
   logic [DATA_W-1:0] w_gen_word, w_pred_word, w_mismatch;
   logic [FILL_W-1:0] w_fill_last;
   logic [POP_W-1:0]  w_pop;
   logic [SUM_W-1:0]  w_sum;
   logic [ERR_W-1:0]  w_err_sat;

   assign w_mode_chg  = (mode != r_mode);
   assign w_mask      = prbs_mask(mode);
   assign w_fill_last = FILL_W'(fill_words(mode, DATA_W) - 1);
   assign w_mismatch  = w_pred_word ^ chk_data;

   prbs_step #(.DATA_W(DATA_W), .USE_FB(1'b0)) u_gen_step (
      .i_state      (r_gen_lfsr),
      .i_mode       (mode),
      .o_word       (w_gen_word),
      .o_next_state (w_gen_next)
   );

   // The checker LFSR holds the last N bits seen, so the next bits on the
   // line are the feedback bits rather than the shifted-out ones.
   prbs_step #(.DATA_W(DATA_W), .USE_FB(1'b1)) u_chk_step (
      .i_state      (r_chk_lfsr),
      .i_mode       (mode),
      .o_word       (w_pred_word),
      .o_next_state (w_chk_next)
   );

   always_comb begin
      w_seed = r_chk_lfsr;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         w_seed = ((w_seed << 1) | LFSR_W'(chk_data[i])) & w_mask;
      end
   end

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < DATA_W; i++) begin
         w_pop = w_pop + POP_W'(w_mismatch[i]);
      end
      w_sum     = SUM_W'(r_err_count) + SUM_W'(w_pop);
      w_err_sat = (w_sum > SUM_W'({ERR_W{1'b1}})) ? {ERR_W{1'b1}} : w_sum[ERR_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode      <= MODE_PRBS7;
         r_gen_lfsr  <= LFSR_W'(1);
         r_gen_data  <= '0;
         r_gen_valid <= 1'b0;
      end else begin
         r_mode <= mode;
         if (w_mode_chg) begin
            r_gen_lfsr  <= LFSR_W'(1);
            r_gen_valid <= 1'b0;
         end else if (en) begin
            r_gen_lfsr  <= w_gen_next;
            r_gen_data  <= w_gen_word ^ DATA_W'(inject_err);
            r_gen_valid <= 1'b1;
         end else begin
            r_gen_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_chk_lfsr_next = r_chk_lfsr;
      w_fill_next     = r_fill_cnt;
      w_good_next     = r_good_cnt;
      w_bad_next      = r_bad_cnt;
      w_err_word_next = 1'b0;
      w_err_acc       = 1'b0;
      if (w_mode_chg) begin
         w_state_next = ST_HUNT;
         w_fill_next  = '0;
         w_good_next  = '0;
         w_bad_next   = '0;
      end else if (chk_valid) begin
         case (r_state)
            ST_HUNT: begin
               w_chk_lfsr_next = w_seed;
               if (r_fill_cnt == w_fill_last) begin
                  w_fill_next = '0;
                  if (w_seed != '0) begin
                     w_state_next = ST_VERIFY;
                  end
               end else begin
                  w_fill_next = r_fill_cnt + FILL_W'(1);
               end
            end
            ST_VERIFY: begin
               w_chk_lfsr_next = w_chk_next;
               if (w_mismatch != '0) begin
                  w_state_next = ST_HUNT;
                  w_good_next  = '0;
               end else if (r_good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                  w_state_next = ST_LOCKED;
                  w_good_next  = '0;
                  w_bad_next   = '0;
               end else begin
                  w_good_next = r_good_cnt + GOOD_W'(1);
               end
            end
            ST_LOCKED: begin
               w_chk_lfsr_next = w_chk_next;
               w_err_acc       = 1'b1;
               if (w_mismatch != '0) begin
                  w_err_word_next = 1'b1;
                  if (r_bad_cnt == BAD_W'(UNLOCK_CNT - 1)) begin
                     w_state_next = ST_HUNT;
                     w_bad_next   = '0;
                  end else begin
                     w_bad_next = r_bad_cnt + BAD_W'(1);
                  end
               end else begin
                  w_bad_next = '0;
               end
            end
            default: begin
               w_state_next = ST_HUNT;
               w_fill_next  = '0;
               w_good_next  = '0;
               w_bad_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_HUNT;
         r_chk_lfsr <= LFSR_W'(1);
         r_fill_cnt <= '0;
         r_good_cnt <= '0;
         r_bad_cnt  <= '0;
         r_err_word <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_chk_lfsr <= w_chk_lfsr_next;
         r_fill_cnt <= w_fill_next;
         r_good_cnt <= w_good_next;
         r_bad_cnt  <= w_bad_next;
         r_err_word <= w_err_word_next;
      end
   end

   // Clear wins over a same-cycle accumulation; the count survives loss of lock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_count <= '0;
      end else if (clr_cnt) begin
         r_err_count <= '0;
      end else if (w_err_acc) begin
         r_err_count <= w_err_sat;
      end
   end

   assign gen_data  = r_gen_data;
   assign gen_valid = r_gen_valid;
   assign locked    = (r_state == ST_LOCKED);
   assign err_count = r_err_count;
   assign err_word  = r_err_word;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Randomised loopback bench for prbs_gen_chk against a sequence-level model
// built from the PRBS recurrence o[j] = o[j-N] ^ o[j-T].
module tb_prbs_gen_chk;

   localparam int DATA_W     = 8;
   localparam int LOCK_CNT   = 4;
   localparam int UNLOCK_CNT = 4;
   localparam int ERR_W      = 6;
   localparam int ERR_MAX    = (1 << ERR_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic [1:0]        mode = 2'b00;
   logic              inject_err = 1'b0;
   logic [DATA_W-1:0] gen_data;
   logic              gen_valid;
   logic [DATA_W-1:0] chk_data = '0;
   logic              chk_valid = 1'b0;
   logic              clr_cnt = 1'b0;
   logic              locked;
   logic [ERR_W-1:0]  err_count;
   logic              err_word;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   prbs_gen_chk #(
      .DATA_W(DATA_W), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(ERR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .inject_err(inject_err),
      .gen_data(gen_data), .gen_valid(gen_valid), .chk_data(chk_data),
      .chk_valid(chk_valid), .clr_cnt(clr_cnt), .locked(locked),
      .err_count(err_count), .err_word(err_word)
   );

   // ---------------- reference model ----------------
   int                m_mode;
   bit                gseq[$];
   int                gpos;
   logic [DATA_W-1:0] m_gen_data;
   bit                m_gen_valid;
   bit                cseq[$];
   int                c_phase;      // 0 hunt, 1 verify, 2 locked
   int                c_fill, c_good, c_bad;
   int                m_err;
   bit                m_err_word;

   function automatic int len_of(input int md);
      return (md == 0) ? 7 : (md == 1) ? 15 : (md == 2) ? 23 : 31;
   endfunction

   function automatic int tap_of(input int md);
      return (md == 0) ? 6 : (md == 1) ? 14 : (md == 2) ? 18 : 28;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic gen_reload();
      int n;
      n = len_of(m_mode);
      gseq.delete();
      for (int i = 0; i < n - 1; i++) gseq.push_back(1'b0);
      gseq.push_back(1'b1);
      gpos = 0;
   endtask

   task automatic gen_bit(input int k, output bit b);
      int n, t, j;
      n = len_of(m_mode);
      t = tap_of(m_mode);
      while (gseq.size() <= k) begin
         j = gseq.size();
         gseq.push_back(gseq[j-n] ^ gseq[j-t]);
      end
      b = gseq[k];
   endtask

   task automatic model_reset();
      m_mode = 0;
      gen_reload();
      m_gen_data  = '0;
      m_gen_valid = 1'b0;
      cseq.delete();
      c_phase = 0; c_fill = 0; c_good = 0; c_bad = 0;
      m_err = 0;
      m_err_word = 1'b0;
   endtask

   task automatic checker_word(input logic [DATA_W-1:0] d);
      int n, t, j, errs;
      bit p, nz;
      n = len_of(m_mode);
      t = tap_of(m_mode);
      if (c_phase == 0) begin
         for (int i = DATA_W - 1; i >= 0; i--) cseq.push_back(d[i]);
         c_fill++;
         if (c_fill == (n + DATA_W - 1) / DATA_W) begin
            c_fill = 0;
            nz = 1'b0;
            for (int i = 1; i <= n; i++) nz |= cseq[cseq.size() - i];
            if (nz) c_phase = 1;
         end
      end else begin
         errs = 0;
         for (int i = DATA_W - 1; i >= 0; i--) begin
            j = cseq.size();
            p = cseq[j-n] ^ cseq[j-t];
            cseq.push_back(p);
            if (p != d[i]) errs++;
         end
         if (c_phase == 1) begin
            if (errs != 0) begin
               c_phase = 0; c_good = 0;
            end else begin
               c_good++;
               if (c_good == LOCK_CNT) begin
                  c_phase = 2; c_good = 0; c_bad = 0;
               end
            end
         end else begin
            m_err = (m_err + errs > ERR_MAX) ? ERR_MAX : m_err + errs;
            if (errs != 0) begin
               m_err_word = 1'b1;
               c_bad++;
               if (c_bad == UNLOCK_CNT) begin
                  c_phase = 0; c_bad = 0;
               end
            end else begin
               c_bad = 0;
            end
         end
      end
      while (cseq.size() > 64) void'(cseq.pop_front());
   endtask

   task automatic model_edge(input bit e, input int md, input bit inj, input bit clr,
                             input logic [DATA_W-1:0] cdata, input bit cvalid);
      logic [DATA_W-1:0] w;
      bit b;
      m_err_word = 1'b0;
      if (md != m_mode) begin
         m_mode = md;
         gen_reload();
         m_gen_valid = 1'b0;
         c_phase = 0; c_fill = 0; c_good = 0; c_bad = 0;
      end else begin
         if (e) begin
            for (int i = 0; i < DATA_W; i++) begin
               gen_bit(gpos + i, b);
               w[DATA_W-1-i] = b;
            end
            gpos += DATA_W;
            m_gen_data  = w ^ DATA_W'(inj);
            m_gen_valid = 1'b1;
         end else begin
            m_gen_valid = 1'b0;
         end
         if (cvalid) checker_word(cdata);
      end
      if (clr) m_err = 0;
   endtask

   // ---------------- stimulus ----------------
   task automatic compare_all();
      check_val("gen_data",  32'(gen_data),  32'(m_gen_data));
      check_val("gen_valid", 32'(gen_valid), 32'(m_gen_valid));
      check_val("locked",    32'(locked),    32'(c_phase == 2));
      check_val("err_count", 32'(err_count), 32'(m_err));
      check_val("err_word",  32'(err_word),  32'(m_err_word));
   endtask

   // Loopback through the model's expected generator word, optionally corrupted.
   task automatic cycle(input bit e, input logic [1:0] md, input bit inj, input bit clr,
                        input logic [DATA_W-1:0] corrupt);
      logic [DATA_W-1:0] cd;
      bit cv;
      cd = m_gen_data ^ corrupt;
      cv = m_gen_valid;
      en = e; mode = md; inject_err = inj; clr_cnt = clr;
      chk_data = cd; chk_valid = cv;
      @(posedge clk);
      model_edge(e, int'(md), inj, clr, cd, cv);
      #1;
      compare_all();
   endtask

   task automatic check_zero_outputs(input string tag);
      check_val({tag, "_gen_data"},  32'(gen_data),  32'd0);
      check_val({tag, "_gen_valid"}, 32'(gen_valid), 32'd0);
      check_val({tag, "_locked"},    32'(locked),    32'd0);
      check_val({tag, "_err_count"}, 32'(err_count), 32'd0);
      check_val({tag, "_err_word"},  32'(err_word),  32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en = 1'b0; inject_err = 1'b0; clr_cnt = 1'b0;
      chk_valid = 1'b0; chk_data = '0; mode = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [1:0]        rmode;
      logic [DATA_W-1:0] corrupt;

      do_reset();

      // PRBS7 first word and period of 127 words (1016 bits = 8 periods)
      cycle(1'b1, 2'b00, 1'b0, 1'b0, '0);
      check_val("prbs7_first", 32'(gen_data), 32'h02);
      for (int i = 2; i <= 128; i++) cycle(1'b1, 2'b00, 1'b0, 1'b0, '0);
      check_val("prbs7_period", 32'(gen_data), 32'h02);
      $display("phase prbs7: total=%0d", total);

      // PRBS31 loopback lock and long clean run
      for (int i = 0; i < 2000; i++) cycle(1'b1, 2'b11, 1'b0, 1'b0, '0);
      check_val("prbs31_locked", 32'(locked), 32'd1);
      check_val("prbs31_clean", 32'(err_count), 32'd0);
      $display("phase prbs31 lock: total=%0d", total);

      // single injected error
      cycle(1'b1, 2'b11, 1'b1, 1'b0, '0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 2'b11, 1'b0, 1'b0, '0);
      check_val("inject_count", 32'(err_count), 32'd1);
      $display("phase inject: total=%0d", total);

      // four inverted words force unlock, then relock, then saturate
      for (int i = 0; i < 4; i++) cycle(1'b1, 2'b11, 1'b0, 1'b0, '1);
      check_val("unlock", 32'(locked), 32'd0);
      check_val("unlock_count", 32'(err_count), 32'd33);
      for (int i = 0; i < 20; i++) cycle(1'b1, 2'b11, 1'b0, 1'b0, '0);
      check_val("relock", 32'(locked), 32'd1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 2'b11, 1'b0, 1'b0, '1);
      check_val("err_sat", 32'(err_count), 32'(ERR_MAX));
      for (int i = 0; i < 20; i++) cycle(1'b1, 2'b11, 1'b0, 1'b0, '0);
      $display("phase unlock/saturate: total=%0d", total);

      // clear in the same cycle as a counted error, then mode change 11 -> 01
      cycle(1'b1, 2'b11, 1'b1, 1'b0, '0);
      cycle(1'b1, 2'b11, 1'b0, 1'b1, '0);
      check_val("clr_priority", 32'(err_count), 32'd0);
      cycle(1'b1, 2'b01, 1'b0, 1'b0, '0);
      check_val("mode_chg_unlock", 32'(locked), 32'd0);
      for (int i = 0; i < 30; i++) cycle(1'b1, 2'b01, 1'b0, 1'b0, '0);
      check_val("prbs15_locked", 32'(locked), 32'd1);
      $display("phase mode change: total=%0d", total);

      // randomised traffic
      rmode = 2'b01;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) rmode = 2'($urandom_range(0, 3));
         corrupt = '0;
         if ($urandom_range(0, 49) == 0) corrupt[$urandom_range(0, DATA_W - 1)] = 1'b1;
         cycle($urandom_range(0, 9) != 0, rmode,
               $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0, corrupt);
      end
      $display("phase random: total=%0d", total);

      // asynchronous reset in the middle of a cycle
      #3;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("async_rst");
      do_reset();
      for (int i = 0; i < 40; i++) cycle(1'b1, 2'b10, 1'b0, 1'b0, '0);
      check_val("prbs23_locked", 32'(locked), 32'd1);
      $display("phase async reset: total=%0d", total);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
